risc_alu_seq: RTL and testbench

// Parametrised, handshaked successor to the 32-bit combinational ALU, sitting between decode/operand fetch and writeback.

---
 rtl/risc_alu_seq.sv | 214 +++++++++++++++++++++
 tb/tb_risc_alu_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_alu_seq.sv
// Handshaked RV32I ALU with registered result/flags and an optional iterative
// shift-add multiplier. Single-cycle ops complete on the accept edge.
module risc_alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_cf,
  output logic             out_vf,
  output logic             out_err,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf(input logic a_msb, input logic b_msb_eff, input logic r_msb);
    return (a_msb == b_msb_eff) && (r_msb != a_msb);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, vf_q, vf_d, err_q, err_d;
  logic             load_s;

  logic [WIDTH:0]   sum_s, diff_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_res_s, acc_step_s;
  logic             alu_cf_s, alu_vf_s, alu_err_s, alu_mul_s;
  logic             accept_s;

  assign in_ready = rst_n && (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign busy     = (state_q == S_MUL);

  assign sum_s      = {1'b0, in_a} + {1'b0, in_b};
  assign diff_s     = {1'b0, in_a} - {1'b0, in_b};
  assign shamt_s    = in_b[SHW-1:0];
  assign acc_step_s = acc_q + (mul_b_q[0] ? mul_a_q : {WIDTH{1'b0}});

  // Single-cycle ALU datapath on the request operands.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_cf_s  = 1'b0;
    alu_vf_s  = 1'b0;
    alu_err_s = 1'b0;
    alu_mul_s = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_cf_s  = sum_s[WIDTH];
        alu_vf_s  = ovf(in_a[WIDTH-1], in_b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_cf_s  = diff_s[WIDTH];
        alu_vf_s  = ovf(in_a[WIDTH-1], ~in_b[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_SLL:  alu_res_s = in_a << shamt_s;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_XOR:  alu_res_s = in_a ^ in_b;
      OP_SRL:  alu_res_s = in_a >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(in_a) >>> shamt_s);
      OP_OR:   alu_res_s = in_a | in_b;
      OP_AND:  alu_res_s = in_a & in_b;
      OP_MUL: begin
        if (MUL_EN) begin
          alu_mul_s = 1'b1;
        end else begin
          alu_err_s = 1'b1;
        end
      end
      default: alu_err_s = 1'b1;
    endcase
  end

  // Next-state: accept, multiply iteration and output-register load/consume.
  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cf_d    = cf_q;
    vf_d    = vf_q;
    err_d   = err_q;
    load_s  = 1'b0;
    if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    case (state_q)
      S_IDLE: begin
        if (accept_s && alu_mul_s) begin
          state_d = S_MUL;
          mul_a_d = in_a;
          mul_b_d = in_b;
          acc_d   = {WIDTH{1'b0}};
          cnt_d   = CNT_LAST;
        end else if (accept_s) begin
          load_s  = 1'b1;
          valid_d = 1'b1;
          res_d   = alu_res_s;
          cf_d    = alu_cf_s;
          vf_d    = alu_vf_s;
          err_d   = alu_err_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        acc_d   = acc_step_s;
        if (cnt_q == {SHW{1'b0}}) begin
          state_d = S_IDLE;
          load_s  = 1'b1;
          valid_d = 1'b1;
          res_d   = acc_step_s;
          cf_d    = 1'b0;
          vf_d    = 1'b0;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_s) begin
      zf_d = (res_d == {WIDTH{1'b0}});
      sf_d = res_d[WIDTH-1];
    end else begin
      zf_d = zf_q;
      sf_d = sf_q;
    end
  end

  // State, multiplier and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mul_a_q <= {WIDTH{1'b0}};
      mul_b_q <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      cnt_q   <= {SHW{1'b0}};
      valid_q <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      cf_q    <= cf_d;
      vf_q    <= vf_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_zf     = zf_q;
  assign out_sf     = sf_q;
  assign out_cf     = cf_q;
  assign out_vf     = vf_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_risc_alu_seq.sv
// Self-checking bench for risc_alu_seq: directed vector table, multi-cycle
// corner sequences and a randomized run against a scoreboard model.
module tb_risc_alu_seq;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [3:0] in_op;
  logic [31:0] in_a, in_b, out_result;
  logic out_zf, out_sf, out_cf, out_vf, out_err, busy;

  logic v0_in_valid, v0_in_ready, v0_out_valid, v0_out_ready;
  logic [3:0] v0_in_op;
  logic [31:0] v0_in_a, v0_in_b, v0_out_result;
  logic v0_zf, v0_sf, v0_cf, v0_vf, v0_err, v0_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  risc_alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zf(out_zf),
    .out_sf(out_sf), .out_cf(out_cf), .out_vf(out_vf), .out_err(out_err), .busy(busy)
  );

  risc_alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(v0_in_valid), .in_ready(v0_in_ready),
    .in_op(v0_in_op), .in_a(v0_in_a), .in_b(v0_in_b), .out_valid(v0_out_valid),
    .out_ready(v0_out_ready), .out_result(v0_out_result), .out_zf(v0_zf),
    .out_sf(v0_sf), .out_cf(v0_cf), .out_vf(v0_vf), .out_err(v0_err), .busy(v0_busy)
  );

  wire [36:0] tuple    = {out_err, out_zf, out_sf, out_cf, out_vf, out_result};
  wire [36:0] v0_tuple = {v0_err, v0_zf, v0_sf, v0_cf, v0_vf, v0_out_result};

  function automatic logic [36:0] mk(input bit e, input bit z, input bit s, input bit c,
                                     input bit v, input logic [31:0] r);
    return {e, z, s, c, v, r};
  endfunction

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned ua, ub, p;
    longint sa, sb, sr;
    int sh;
    logic [31:0] r;
    bit c, v, e;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    sh = int'(b[4:0]);
    r = 32'h0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      OP_ADD:  begin p = ua + ub; r = p[31:0]; c = (p > 64'hFFFF_FFFF);
                     sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      OP_SUB:  begin p = ua - ub; r = p[31:0]; c = (ua < ub);
                     sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      OP_SLL:  begin p = ua << sh; r = p[31:0]; end
      OP_SRL:  begin p = ua >> sh; r = p[31:0]; end
      OP_SRA:  begin sr = sa >>> sh; r = sr[31:0]; end
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_MUL:  begin p = ua * ub; r = p[31:0]; end
      default: e = 1'b1;
    endcase
    return {e, (r == 32'h0), r[31], c, v, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs [16];
  logic [3:0] op_tab [13];
  logic [36:0] exp_q [$];
  logic [31:0] got_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, ri;
    bit hold_ok, pend, prev_hold;
    logic [36:0] prev_tuple;
    logic [31:0] corner [4];

    vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, mk(0,0,1,0,1,32'h8000_0000)};
    vecs[1]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, mk(0,1,0,0,0,32'h0000_0000)};
    vecs[2]  = '{OP_SUB,  32'h0000_0003, 32'h0000_0005, mk(0,0,1,1,0,32'hFFFF_FFFE)};
    vecs[3]  = '{OP_SLTU, 32'h0000_0003, 32'h0000_0005, mk(0,0,0,0,0,32'h0000_0001)};
    vecs[4]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, mk(0,0,0,0,0,32'h0000_0001)};
    vecs[5]  = '{OP_SRA,  32'h8000_0000, 32'h0000_0021, mk(0,0,1,0,0,32'hC000_0000)};
    vecs[6]  = '{OP_SRL,  32'h8000_0000, 32'h0000_0021, mk(0,0,0,0,0,32'h4000_0000)};
    vecs[7]  = '{OP_SLL,  32'h0000_0001, 32'h0000_001F, mk(0,0,1,0,0,32'h8000_0000)};
    vecs[8]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, mk(0,1,0,1,0,32'h0000_0000)};
    vecs[9]  = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, mk(0,0,0,0,1,32'h7FFF_FFFF)};
    vecs[10] = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, mk(0,0,0,0,0,32'h0FF0_0FF0)};
    vecs[11] = '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, mk(0,0,1,0,0,32'hFFFF_FFFF)};
    vecs[12] = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, mk(0,0,1,0,0,32'hF000_F000)};
    vecs[13] = '{4'b1010, 32'h0000_0005, 32'h0000_0006, mk(1,1,0,0,0,32'h0000_0000)};
    vecs[14] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, mk(0,1,0,0,0,32'h0000_0000)};
    vecs[15] = '{OP_SRA,  32'h7FFF_FFFF, 32'h0000_0004, mk(0,0,0,0,0,32'h07FF_FFFF)};
    op_tab = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
               OP_OR, OP_AND, OP_MUL, 4'b1010, 4'b1111};
    corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_op = OP_ADD; in_a = 32'h0; in_b = 32'h0;
    v0_in_valid = 1'b0; v0_out_ready = 1'b1; v0_in_op = OP_ADD; v0_in_a = 32'h0; v0_in_b = 32'h0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tuple", tuple, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vector table, latency 1
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_tuple", i), tuple, vecs[i].exp);
    end
    flush();

    // MUL latency and busy window
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'h0001_0000; in_b = 32'h0001_0001;
    tick();
    in_valid = 1'b0;
    n = 0; hold_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
      tick();
      n++;
    end
    chk("mul_busy_window", hold_ok, 1);
    chk("mul_latency", n, 32);
    chk("mul_tuple", tuple, mk(0,0,0,0,0,32'h0001_0000));
    chk("mul_busy_done", busy, 0);
    flush();

    // MUL reported illegal when not built in
    v0_in_valid = 1'b1; v0_in_op = OP_MUL; v0_in_a = 32'h3; v0_in_b = 32'h4;
    tick();
    v0_in_valid = 1'b0;
    chk("nomul_valid", v0_out_valid, 1);
    chk("nomul_tuple", v0_tuple, mk(1,1,0,0,0,32'h0));

    // Backpressure: three back-to-back ADDs with consumer stalled
    ri = 0; got_q.delete();
    for (int c = 0; c < 15; c++) begin
      out_ready = (c >= 5); in_valid = (ri < 3); in_op = OP_ADD; in_a = 32'h0; in_b = ri + 1;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk($sformatf("bp_hold_valid_c%0d", c), out_valid, 1);
        chk($sformatf("bp_hold_result_c%0d", c), out_result, 32'h1);
        chk($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
      end
      if (out_valid && out_ready) got_q.push_back(out_result);
      if (in_valid && in_ready) ri++;
      tick();
    end
    chk("bp_count", got_q.size(), 3);
    for (int k = 0; k < 3 && k < got_q.size(); k++)
      chk($sformatf("bp_order%0d", k), got_q[k], k + 1);
    flush();

    // Reset in the middle of a MUL
    in_valid = 1'b1; in_op = OP_MUL; in_a = $urandom; in_b = $urandom;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid_mul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post_arst_no_output", out_valid, 0);
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'h2; in_b = 32'h3;
    tick();
    in_valid = 1'b0;
    chk("post_arst_add_valid", out_valid, 1);
    chk("post_arst_add_tuple", tuple, mk(0,0,0,0,0,32'h5));
    flush();

    // Randomized stream against the scoreboard
    pend = 1'b0; prev_hold = 1'b0; prev_tuple = '0; exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      if (!pend) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op = op_tab[$urandom_range(0, 12)];
        in_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        in_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        pend = in_valid;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_hold) begin
        chk("rand_hold_valid", out_valid, 1);
        chk("rand_hold_tuple", tuple, prev_tuple);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rand_spurious: got output %0h with nothing outstanding", tuple);
        end else begin
          chk("rand_out", tuple, exp_q.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_tuple = tuple;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_a, in_b));
        pend = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) chk("drain_out", tuple, exp_q.pop_front());
      tick();
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
